// File: rtl/imm_encoder.sv
// Packs a signed immediate and register/opcode fields into a RISC-V I/S/B/J instruction word.
// Two-stage valid/ready pipeline with range checks, a running write address and an error counter.
module imm_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_immsrc,
  input  logic [31:0]          in_imm,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [2:0]           in_funct3,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic                 addr_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [1:0]           FMT_I   = 2'b00;
  localparam logic [1:0]           FMT_S   = 2'b01;
  localparam logic [1:0]           FMT_B   = 2'b10;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic                 r_s1_valid;
  logic [31:0]          r_s1_instr;
  logic                 r_s1_err;
  logic                 r_s2_valid;
  logic [31:0]          r_instr;
  logic                 r_err;
  logic [ADDR_W-1:0]    r_addr;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic signed [31:0]   w_imm_s;
  logic [31:0]          w_imm;
  logic                 w_err;
  logic [31:0]          w_instr;
  logic                 w_s1_adv;
  logic                 w_in_fire;
  logic                 w_out_fire;

  assign w_s1_adv   = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s1_adv;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  assign out_valid  = r_s2_valid;
  assign out_instr  = r_instr;
  assign out_err    = r_err;
  assign out_addr   = r_addr;
  assign err_count  = r_err_cnt;

  // Range/alignment check, then scatter the (possibly zeroed) immediate into the format
  always_comb begin
    w_imm_s = $signed(in_imm);
    case (in_immsrc)
      FMT_I, FMT_S: w_err = (w_imm_s < -32'sd2048) || (w_imm_s > 32'sd2047);
      FMT_B:        w_err = (w_imm_s < -32'sd4096) || (w_imm_s > 32'sd4094) || in_imm[0];
      default:      w_err = (w_imm_s < -32'sd1048576) || (w_imm_s > 32'sd1048574) || in_imm[0];
    endcase
    w_imm = w_err ? 32'd0 : in_imm;
    case (in_immsrc)
      FMT_I:   w_instr = {w_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S:   w_instr = {w_imm[11:5], in_rs2, in_rs1, in_funct3, w_imm[4:0], in_opcode};
      FMT_B:   w_instr = {w_imm[12], w_imm[10:5], in_rs2, in_rs1, in_funct3,
                          w_imm[4:1], w_imm[11], in_opcode};
      default: w_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], in_rd, in_opcode};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_instr <= '0;
      r_s1_err   <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_instr <= w_instr;
      r_s1_err   <= w_err;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Output stage holds its word while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_instr    <= '0;
      r_err      <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_instr <= r_s1_instr;
        r_err   <= r_s1_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= BASE_ADDR;
      r_err_cnt <= '0;
    end else begin
      if (addr_clr)        r_addr <= BASE_ADDR;
      else if (w_out_fire) r_addr <= r_addr + ADDR_W'(4);
      if (w_out_fire && r_err && (r_err_cnt != ERR_MAX))
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed-vector and round-trip bench for imm_encoder; a second instance covers address wrap
// and counter saturation.
module tb_imm_encoder;

  localparam logic [31:0] WBASE = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, addr_clr, out_valid, out_ready, out_err;
  logic [1:0]  in_immsrc;
  logic [31:0] in_imm, out_instr, out_addr;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [7:0]  err_count;
  logic        w_in_ready, w_out_valid, w_out_err;
  logic [31:0] w_out_instr, w_out_addr;
  logic [1:0]  w_err_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_addr, exp_waddr, exp_ec, exp_ec_w;

  always #5 clk = ~clk;

  imm_encoder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_immsrc(in_immsrc),
    .in_imm(in_imm), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .addr_clr(addr_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  imm_encoder #(.ADDR_W(32), .BASE_ADDR(WBASE), .ERR_CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_immsrc(in_immsrc),
    .in_imm(in_imm), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .addr_clr(addr_clr), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_instr(w_out_instr), .out_addr(w_out_addr), .out_err(w_out_err),
    .err_count(w_err_count)
  );

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [31:0] exp_instr;
    logic        exp_err;
    bit          by_decode;
  } exp_t;

  vec_t vecs[13];
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dec_imm(input logic [31:0] w, input logic [1:0] s);
    case (s)
      2'b00:   return {{20{w[31]}}, w[31:20]};
      2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
      2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  task automatic drive_vec(input vec_t v);
    in_immsrc = v.src; in_imm = v.imm; in_opcode = v.op; in_rd = v.rd;
    in_funct3 = v.f3;  in_rs1 = v.rs1; in_rs2 = v.rs2;
  endtask

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_addr = 0; exp_waddr = WBASE; exp_ec = 0; exp_ec_w = 0;
  endtask

  task automatic note_transfer(input logic err);
    exp_addr  = exp_addr + 4;
    exp_waddr = exp_waddr + 4;
    if (err && exp_ec < 255) exp_ec++;
    if (err && exp_ec_w < 3) exp_ec_w++;
  endtask

  // Streams n words (table or random in-range) and checks every cycle the output is valid
  task automatic run_stream(input int n, input bit rnd, input bit rnd_ready);
    int   sent = 0;
    int   got = 0;
    int   cyc = 0;
    exp_t cur, e;
    vec_t v;
    int   iv;
    while (got < n && cyc < 4 * n + 100) begin
      @(negedge clk);
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < n) begin
        if (rnd) begin
          v.src = 2'($urandom_range(0, 3));
          case (v.src)
            2'b00, 2'b01: iv = int'($urandom_range(0, 4095)) - 2048;
            2'b10:        iv = (int'($urandom_range(0, 4095)) - 2048) * 2;
            default:      iv = (int'($urandom_range(0, 1048575)) - 524288) * 2;
          endcase
          v.imm = 32'(iv); v.op = 7'($urandom); v.rd = 5'($urandom); v.f3 = 3'($urandom);
          v.rs1 = 5'($urandom); v.rs2 = 5'($urandom); v.exp_instr = '0; v.exp_err = 1'b0;
        end else begin
          v = vecs[sent];
        end
        drive_vec(v);
        in_valid = 1'b1;
        cur = '{v.src, v.imm, v.op, v.exp_instr, v.exp_err, rnd};
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = q[0];
          if (e.by_decode) begin
            chk("roundtrip_imm", dec_imm(out_instr, e.src), e.imm);
            chk("roundtrip_op", 32'(out_instr[6:0]), 32'(e.op));
          end else begin
            chk("vec_instr", out_instr, e.exp_instr);
          end
          chk("stream_err", 32'(out_err), 32'(e.exp_err));
          chk("stream_addr", out_addr, 32'(exp_addr));
          chk("stream_wrap_addr", w_out_addr, 32'(exp_waddr));
          if (out_ready) begin
            void'(q.pop_front());
            got++;
            note_transfer(e.exp_err);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(cur);
        sent++;
      end
      cyc++;
    end
    chk("stream_complete", 32'(got), 32'(n));
    q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    chk("err_count", 32'(err_count), 32'(exp_ec));
    chk("err_count_sat", 32'(w_err_count), 32'(exp_ec_w));
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 7'h13, 5'd1,  3'd0, 5'd5,  5'd7,  32'hFFF28093, 1'b0};
    vecs[1]  = '{2'b10, 32'hFFFF_FFFC, 7'h63, 5'd0,  3'd1, 5'd1,  5'd2,  32'hFE209EE3, 1'b0};
    vecs[2]  = '{2'b10, 32'h0000_0003, 7'h63, 5'd0,  3'd1, 5'd1,  5'd2,  32'h00209063, 1'b1};
    vecs[3]  = '{2'b11, 32'h0000_0800, 7'h6F, 5'd1,  3'd7, 5'd31, 5'd31, 32'h001000EF, 1'b0};
    vecs[4]  = '{2'b11, 32'h0010_0000, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd0,  32'h000000EF, 1'b1};
    vecs[5]  = '{2'b01, 32'h0000_07FF, 7'h23, 5'd31, 3'd2, 5'd2,  5'd3,  32'h7E312FA3, 1'b0};
    vecs[6]  = '{2'b00, 32'h0000_0800, 7'h13, 5'd1,  3'd0, 5'd5,  5'd0,  32'h00028093, 1'b1};
    vecs[7]  = '{2'b00, 32'hFFFF_F800, 7'h13, 5'd1,  3'd0, 5'd5,  5'd0,  32'h80028093, 1'b0};
    vecs[8]  = '{2'b10, 32'h0000_0FFE, 7'h63, 5'd0,  3'd1, 5'd1,  5'd2,  32'h7E209FE3, 1'b0};
    vecs[9]  = '{2'b10, 32'h0000_1000, 7'h63, 5'd0,  3'd1, 5'd1,  5'd2,  32'h00209063, 1'b1};
    vecs[10] = '{2'b11, 32'hFFF0_0000, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd0,  32'h800000EF, 1'b0};
    vecs[11] = '{2'b11, 32'h0000_0001, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd0,  32'h000000EF, 1'b1};
    vecs[12] = '{2'b01, 32'hFFFF_F7FF, 7'h23, 5'd0,  3'd2, 5'd2,  5'd3,  32'h00312023, 1'b1};
    drive_vec(vecs[0]);

    // Reset values, sampled while reset is held
    rst = 1'b1; in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_wrap_addr", w_out_addr, WBASE);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset_dut();

    // Two-edge latency for a single word
    drive_vec(vecs[0]); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_instr", out_instr, 32'hFFF28093);
    chk("lat_err", 32'(out_err), 32'd0);
    chk("lat_addr", out_addr, 32'd0);
    chk("lat_wrap_addr", w_out_addr, WBASE);
    note_transfer(1'b0);

    run_stream(13, 1'b0, 1'b0);

    // Back-to-back with random backpressure from a fresh reset
    reset_dut();
    run_stream(8, 1'b0, 1'b1);

    run_stream(10000, 1'b1, 1'b0);

    // addr_clr coinciding with a transfer: next word starts at the base address
    out_ready = 1'b0;
    drive_vec(vecs[0]); in_valid = 1'b1;
    @(negedge clk);
    drive_vec(vecs[1]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("clr_pre_valid", 32'(out_valid), 32'd1);
    chk("clr_pre_addr", out_addr, 32'(exp_addr));
    out_ready = 1'b1; addr_clr = 1'b1;
    @(negedge clk);
    addr_clr = 1'b0; out_ready = 1'b0;
    chk("clr_next_valid", 32'(out_valid), 32'd1);
    chk("clr_next_instr", out_instr, 32'hFE209EE3);
    chk("clr_next_addr", out_addr, 32'd0);
    chk("clr_next_wrap_addr", w_out_addr, WBASE);

    // Async reset with two words in flight
    drive_vec(vecs[2]); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("flight_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_addr", out_addr, 32'd0);
    chk("arst_wrap_addr", w_out_addr, WBASE);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_partial", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
